// File: rtl/lu_pipe_if.sv
// Operand/result bundle for lu_pipe: valid/ready on the operand side, valid/ready on the result side.
// master = operand source plus result consumer; slave = the logic unit.
interface lu_pipe_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          acc_sel;
  logic          acc_clr;
  logic [W-1:0]  s;
  logic          zero;
  logic          parity;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] op_count;

  modport master (
    output in_valid, a, b, op, acc_sel, acc_clr, out_ready,
    input  in_ready, s, zero, parity, out_valid, op_count
  );

  modport slave (
    input  in_valid, a, b, op, acc_sel, acc_clr, out_ready,
    output in_ready, s, zero, parity, out_valid, op_count
  );
endinterface

// File: rtl/lu_pipe.sv
// W-bit 8-op logic unit with accumulator, one output register stage (result the cycle after accept).
// in_ready = !out_valid || out_ready: a stalled result blocks new operands, no skid buffer.
module lu_pipe #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input logic       clk,
  input logic       reset,
  lu_pipe_if.slave  io
);

  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          zero_q, zero_d;
  logic          parity_q, parity_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] op_count_q, op_count_d;

  logic [W-1:0]  opa;
  logic [W-1:0]  grp;
  logic [W-1:0]  res;
  logic          in_rdy;
  logic          accept;

  // acc_clr takes effect before the accumulator is used as operand A.
  always_comb begin
    opa = io.acc_sel ? (io.acc_clr ? '0 : acc_q) : io.a;
    case (io.op[2:1])
      2'b00:   grp = opa & io.b;
      2'b01:   grp = opa | io.b;
      2'b10:   grp = opa ^ io.b;
      default: grp = opa;
    endcase
    res = io.op[0] ? ~grp : grp;
  end

  always_comb begin
    in_rdy      = !out_valid_q || io.out_ready;
    accept      = io.in_valid && in_rdy;
    s_d         = s_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    acc_d       = acc_q;
    if (accept) begin
      s_d         = res;
      zero_d      = (res == '0);
      parity_d    = ^res;
      out_valid_d = 1'b1;
      op_count_d  = op_count_q + CW'(1);
      acc_d       = res;
    end else begin
      if (io.out_ready) out_valid_d = 1'b0;
      if (io.acc_clr)   acc_d       = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q         <= '0;
      zero_q      <= 1'b0;
      parity_q    <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
      acc_q       <= '0;
    end else begin
      s_q         <= s_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
      acc_q       <= acc_d;
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.s         = s_q;
  assign io.zero      = zero_q;
  assign io.parity    = parity_q;
  assign io.out_valid = out_valid_q;
  assign io.op_count  = op_count_q;

endmodule

// File: tb/tb_lu_pipe.sv
// Scoreboard bench for lu_pipe: driver pushes expected results from a behavioural model,
// a monitor compares the presented output every cycle and pops on consume.
module tb_lu_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lu_pipe_if #(.W(8), .CW(4)) bus ();

  lu_pipe #(.W(8), .CW(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  typedef struct packed {
    logic [7:0] s;
    logic       z;
    logic       p;
  } exp_t;

  exp_t       sb[$];
  logic       m_valid;
  logic [7:0] m_acc;
  logic [3:0] m_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'd0:    return x & y;
      3'd1:    return ~(x & y);
      3'd2:    return x | y;
      3'd3:    return ~(x | y);
      3'd4:    return x ^ y;
      3'd5:    return ~(x ^ y);
      3'd6:    return x;
      default: return ~x;
    endcase
  endfunction

  // Called at posedge+1; applies inputs for one cycle and advances the model.
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic asel, input logic aclr, input logic ordy);
    logic       exp_rdy;
    logic [7:0] opa;
    logic [7:0] r;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.op        = op;
    bus.acc_sel   = asel;
    bus.acc_clr   = aclr;
    bus.out_ready = ordy;
    @(negedge clk);
    #1;
    exp_rdy = !m_valid || ordy;
    chk("in_ready", bus.in_ready, exp_rdy);
    if (v && exp_rdy) begin
      opa = asel ? (aclr ? 8'h00 : m_acc) : a;
      r   = ref_op(op, opa, b);
      sb.push_back('{s: r, z: (r == 8'h00), p: ^r});
      m_acc   = r;
      m_cnt   = m_cnt + 4'd1;
      m_valid = 1'b1;
    end else begin
      if (ordy) m_valid = 1'b0;
      if (aclr) m_acc = 8'h00;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 'x, 'x, 'x, 1'b0, 1'b0, ordy);
  endtask

  // Monitor: presented output must match the head of the scoreboard; pop when consumed.
  initial begin
    forever begin
      @(negedge clk);
      chk("op_count", bus.op_count, m_cnt);
      if (m_valid) begin
        chk("out_valid", bus.out_valid, 1'b1);
        chk("s",      bus.s,      sb[0].s);
        chk("zero",   bus.zero,   sb[0].z);
        chk("parity", bus.parity, sb[0].p);
        if (bus.out_ready) void'(sb.pop_front());
      end else begin
        chk("out_valid", bus.out_valid, 1'b0);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    m_valid       = 1'b0;
    m_acc         = 8'h00;
    m_cnt         = 4'd0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.op        = 3'd0;
    bus.acc_sel   = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  bus.in_ready,  1'b1);
    chk("rst_s",         bus.s,         8'h00);
    chk("rst_zero",      bus.zero,      1'b0);
    chk("rst_parity",    bus.parity,    1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_op_count",  bus.op_count,  4'd0);
    reset = 1'b0;

    // Op sweep on a fixed operand pair
    for (int i = 0; i < 8; i++) drive(1'b1, 8'hC3, 8'hA5, 3'(i), 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // Backpressure: result held, further operands refused
    drive(1'b1, 8'hFF, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h12, 8'h34, 3'd2, 1'b0, 1'b0, 1'b0);
    idle(1'b1);

    // Accumulator chain, zero flag, acc_clr without accept
    drive(1'b1, 8'hEE, 8'h01, 3'd2, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 8'hEE, 8'h03, 3'd4, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'hEE, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h77, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'h55, 8'h00, 3'd6, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Counter wrap with back-to-back accepts
    for (int i = 0; i < 17; i++)
      drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    // Asynchronous reset while a result is pending
    drive(1'b1, 8'h5A, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_s",         bus.s,         8'h00);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_op_count",  bus.op_count,  4'd0);
    chk("mid_rst_zero",      bus.zero,      1'b0);
    sb.delete();
    m_valid = 1'b0;
    m_acc   = 8'h00;
    m_cnt   = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 8'h3C, 8'hFF, 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h99, 8'h00, 3'd6, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Random stream
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0)
        drive(1'b0, 'x, 'x, 'x, 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      else
        drive(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
